// File: rtl/dff_en.sv
// -----------------------------------------------------------------------------
// dff_en -- parameterized load-enabled register.
//
// Purpose:
//   A general-purpose pipeline register, used for things like the PC history
//   and the invalid-slot flags. On each rising clk edge, in priority order:
//     rst=1        -> out <= RESET_VAL
//     rst=0, en=1  -> out <= in
//     rst=0, en=0  -> out holds
//   The value is one vector flop with one enable. There are no per-bit enables
//   and no combinational path from the inputs to out.
//
// Parameters:
//   WIDTH      data width in bits (>= 1)
//   RESET_VAL  value loaded on reset. It is typed WIDTH bits wide, so a wider
//              literal is truncated and a narrower one is zero-extended.
//
// Ports (order fixed for positional instantiation):
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous reset, active-high
//   en    in   1      load enable
//   in    in   WIDTH  data to capture
//   out   out  WIDTH  registered value
//   prev  out  WIDTH  only when DFF_EN_PREV_EN is defined. It holds the value
//                     out had just before its most recent load, so a stalled
//                     pipeline can recover its last pre-stall value.
//
// Build option:
//   DFF_EN_PREV_EN  adds the prev port and its shadow flop. When undefined,
//                   neither the port nor the flop exists.
//
// Simulation note: out is X until the first reset edge. An X on en or in
// with rst=0 is allowed to propagate into out and is not masked.
// -----------------------------------------------------------------------------
module dff_en #(
  parameter int unsigned         WIDTH     = 1,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef DFF_EN_PREV_EN
  ,
  output logic [WIDTH-1:0] prev
`endif
);

  logic [WIDTH-1:0] out_q, out_d;

  // A ternary is used instead of if/else so that an X on en merges into
  // out_d rather than silently selecting the hold path.
  always_comb begin
    out_d = en ? in : out_q;
  end

  // Reset wins over a simultaneous load, and that load is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (rst) out_q <= RESET_VAL;
    else     out_q <= out_d;
  end

  assign out = out_q;

`ifdef DFF_EN_PREV_EN
  logic [WIDTH-1:0] prev_q, prev_d;

  // The shadow advances only on a real load, so it stays fixed across a stall.
  always_comb begin
    prev_d = en ? out_q : prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= RESET_VAL;
    else     prev_q <= prev_d;
  end

  assign prev = prev_q;
`endif

endmodule

// File: tb/tb_dff_en.sv
// -----------------------------------------------------------------------------
// tb_dff_en -- self-checking bench for dff_en.
// Two instances are used: u8 (WIDTH=8, RESET_VAL=0) and u1 (WIDTH=1,
// RESET_VAL=1). Inputs are driven 1ns after the rising edge, and outputs are
// checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_dff_en;
  logic       clk = 1'b0;
  logic       rst8, en8, rst1, en1, in1, out1;
  logic [7:0] in8, out8;
`ifdef DFF_EN_PREV_EN
  logic [7:0] prev8;
  logic       prev1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_en #(.WIDTH(8), .RESET_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .in(in8), .out(out8)
`ifdef DFF_EN_PREV_EN
    , .prev(prev8)
`endif
  );

  dff_en #(.WIDTH(1), .RESET_VAL(1'b1)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .in(in1), .out(out1)
`ifdef DFF_EN_PREV_EN
    , .prev(prev1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; en8 = 1'b1; in8 = 8'hA5;
    tick();
    chk8("reset_over_en", out8, 8'h00);
  endtask

  task automatic test_load();
    rst8 = 1'b0; en8 = 1'b1; in8 = 8'h3C;
    #2;
    chk8("load_not_before_edge", out8, 8'h00);
    tick();
    chk8("load_after_edge", out8, 8'h3C);
  endtask

  task automatic test_hold();
    en8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in8 = (i % 2 == 0) ? 8'hFF : 8'h11;
      tick();
      chk8($sformatf("hold_%0d", i), out8, 8'h3C);
    end
  endtask

  task automatic test_reset_vs_load();
    rst8 = 1'b1; en8 = 1'b1; in8 = 8'h77;
    tick();
    chk8("reset_beats_load", out8, 8'h00);
    rst8 = 1'b0;
    tick();
    chk8("load_after_reset", out8, 8'h77);
  endtask

  task automatic test_width1();
    rst1 = 1'b1; en1 = 1'b0; in1 = 1'b0;
    tick();
    checks++;
    if (out1 !== 1'b1) begin errors++; $display("FAIL w1_reset: got %b expected 1", out1); end
    rst1 = 1'b0; en1 = 1'b1; in1 = 1'b0;
    tick();
    checks++;
    if (out1 !== 1'b0) begin errors++; $display("FAIL w1_load0: got %b expected 0", out1); end
    en1 = 1'b0; in1 = 1'b1;
    tick();
    checks++;
    if (out1 !== 1'b0) begin errors++; $display("FAIL w1_hold: got %b expected 0", out1); end
  endtask

`ifdef DFF_EN_PREV_EN
  task automatic test_prev();
    rst8 = 1'b1; en8 = 1'b0; in8 = 8'h00;
    tick();
    chk8("prev_reset_out", out8, 8'h00);
    chk8("prev_reset_prev", prev8, 8'h00);
    rst8 = 1'b0; en8 = 1'b1; in8 = 8'h12;
    tick();
    chk8("prev_ld12_out", out8, 8'h12);
    chk8("prev_ld12_prev", prev8, 8'h00);
    in8 = 8'h34;
    tick();
    chk8("prev_ld34_out", out8, 8'h34);
    chk8("prev_ld34_prev", prev8, 8'h12);
    en8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in8 = 8'($urandom);
      tick();
      chk8($sformatf("prev_stall_out_%0d", i), out8, 8'h34);
      chk8($sformatf("prev_stall_prev_%0d", i), prev8, 8'h12);
    end
  endtask
`endif

  // The reference model keeps a list of the values the register has held
  // since the last reset. out is the newest entry in the list, and prev is
  // the entry before it, or the reset value when only one entry exists.
  task automatic test_random();
    logic [7:0] hist[$];
    logic [7:0] exp_prev;
    logic       m1;
    // Start from a reset so that the model and both DUTs are in step.
    rst8 = 1'b1; rst1 = 1'b1; en8 = 1'b0; en1 = 1'b0;
    tick();
    hist.delete(); hist.push_back(8'h00); m1 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rst8 = ($urandom_range(0, 9) == 0);
      en8  = $urandom_range(0, 1) == 1;
      in8  = 8'($urandom);
      rst1 = ($urandom_range(0, 9) == 0);
      en1  = $urandom_range(0, 1) == 1;
      in1  = 1'($urandom);
      tick();
      if (rst8) begin hist.delete(); hist.push_back(8'h00); end
      else if (en8) hist.push_back(in8);
      if (rst1) m1 = 1'b1; else if (en1) m1 = in1;
      chk8($sformatf("rand_out_%0d", c), out8, hist[$]);
`ifdef DFF_EN_PREV_EN
      exp_prev = (hist.size() > 1) ? hist[hist.size()-2] : 8'h00;
      chk8($sformatf("rand_prev_%0d", c), prev8, exp_prev);
`else
      exp_prev = 8'h00;
`endif
      checks++;
      if (out1 !== m1) begin
        errors++;
        $display("FAIL rand_w1_%0d: got %b expected %b", c, out1, m1);
      end
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  initial begin
    rst8 = 1'b1; en8 = 1'b0; in8 = 8'h00;
    rst1 = 1'b1; en1 = 1'b0; in1 = 1'b0;
    #1;
    test_reset();
    test_load();
    test_hold();
    test_reset_vs_load();
    test_width1();
`ifdef DFF_EN_PREV_EN
    test_prev();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
